// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register carrying a data/control bundle with a valid/ready handshake,
// synchronous bubble-injecting flush, optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_hs #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CTRL_W  = 12,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic              main_valid, main_valid_n;
  logic [DATA_W-1:0] main_data,  main_data_n;
  logic [CTRL_W-1:0] main_ctrl,  main_ctrl_n;
  logic              skid_valid, skid_valid_n;
  logic [DATA_W-1:0] skid_data,  skid_data_n;
  logic [CTRL_W-1:0] skid_ctrl,  skid_ctrl_n;
  logic              ready_q;
  logic              in_fire, out_fire;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

  assign out_fire = main_valid & out_ready;
  // With the skid buffer, in_ready comes straight from a flop so out_ready never reaches it.
  assign in_ready = SKID_EN ? ready_q : (!main_valid | out_ready);
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first; a missed branch would otherwise infer a latch.
    main_valid_n = main_valid;
    main_data_n  = main_data;
    main_ctrl_n  = main_ctrl;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_ctrl_n  = skid_ctrl;

    if (flush) begin
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
      skid_valid_n = 1'b0;
      skid_ctrl_n  = '0;
    end else if (SKID_EN && skid_valid) begin
      // FULL: the skid entry is older than anything upstream, so it moves up first.
      if (out_fire) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        main_ctrl_n  = skid_ctrl;
        skid_valid_n = 1'b0;
        skid_ctrl_n  = '0;
      end
    end else if (SKID_EN && in_fire && main_valid && !out_fire) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
      skid_ctrl_n  = in_ctrl;
    end else if (in_fire) begin
      main_valid_n = 1'b1;
      main_data_n  = in_data;
      main_ctrl_n  = in_ctrl;
    end else if (out_fire) begin
      // Bubble: control goes to zero so it carries no side effects; data is left as is.
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
    end
  end

  // NOTE: the skid entry is a plain register pair, so it is reset along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      ready_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge order-independent.
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      main_ctrl  <= main_ctrl_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_ctrl  <= skid_ctrl_n;
      ready_q    <= !skid_valid_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: a skid instance and a single-register instance share stimulus,
// each checked every cycle against a queue-based occupancy model.
module tb_pipe_stage_hs;

  localparam int DW      = 16;
  localparam int CW      = 12;
  localparam int NW      = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic stall_clr = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic [1:0]    in_ready_v;
  logic [1:0]    out_valid_v;
  logic [DW-1:0] out_data_v  [2];
  logic [CW-1:0] out_ctrl_v  [2];
  logic [NW-1:0] stall_cnt_v [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CNT_W(NW)) dut_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]), .out_ctrl(out_ctrl_v[0]),
    .stall_cnt(stall_cnt_v[0]), .stall_clr(stall_clr)
  );

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CNT_W(NW)) dut_flop (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]), .out_ctrl(out_ctrl_v[1]),
    .stall_cnt(stall_cnt_v[1]), .stall_clr(stall_clr)
  );

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [inst %0d] at %0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  // Model: the stage is a FIFO of held bundles (max 2 with skid, 1 without); everything observable
  // follows from its occupancy. Checked and advanced on the falling edge, where inputs are stable.
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam bit SKID = (g == 0);
    logic [CW+DW-1:0] q[$];
    int cnt = 0;

    always @(negedge clk) begin
      logic exp_ov, exp_ir, ofire, ifire;
      logic [CW+DW-1:0] head;
      if (!rst_n) begin
        q.delete();
        cnt = 0;
        check("reset out_valid", g, 32'(out_valid_v[g]), 32'd0);
        check("reset out_ctrl",  g, 32'(out_ctrl_v[g]),  32'd0);
        check("reset out_data",  g, 32'(out_data_v[g]),  32'd0);
        check("reset stall_cnt", g, 32'(stall_cnt_v[g]), 32'd0);
      end else begin
        exp_ov = (q.size() > 0);
        exp_ir = SKID ? (q.size() < 2) : (!exp_ov || out_ready);
        check("out_valid", g, 32'(out_valid_v[g]), 32'(exp_ov));
        check("in_ready",  g, 32'(in_ready_v[g]),  32'(exp_ir));
        check("stall_cnt", g, 32'(stall_cnt_v[g]), 32'(cnt));
        if (exp_ov) begin
          head = q[0];
          check("out_data", g, 32'(out_data_v[g]), 32'(head[DW-1:0]));
          check("out_ctrl", g, 32'(out_ctrl_v[g]), 32'(head[DW +: CW]));
        end else begin
          check("bubble ctrl", g, 32'(out_ctrl_v[g]), 32'd0);
        end
        ofire = exp_ov && out_ready;
        ifire = in_valid && exp_ir;
        if (stall_clr) cnt = 0;
        else if (exp_ov && !out_ready && cnt < CNT_MAX) cnt++;
        if (ofire) void'(q.pop_front());
        if (flush) q.delete();
        else if (ifire) q.push_back({in_ctrl, in_data});
      end
    end
  end

  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl, input logic clr);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First bundle, one-cycle latency
    step(1'b1, 16'h1234, 12'h0A5, 1'b1, 1'b0, 1'b0);
    check("first out_valid", 0, 32'(out_valid_v[0]), 32'd1);
    check("first out_data",  0, 32'(out_data_v[0]),  32'h1234);
    check("first out_ctrl",  0, 32'(out_ctrl_v[0]),  32'h0A5);
    check("first in_ready",  0, 32'(in_ready_v[0]),  32'd1);

    // Back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), CW'(12'h300 | i), 1'b1, 1'b0, 1'b0);
    check("stream last data", 0, 32'(out_data_v[0]), 32'd8);

    // Back-pressure: bundle 1, then 2 into skid, 3 held upstream
    step(1'b1, 16'h0101, 12'h011, 1'b1, 1'b0, 1'b0);
    in_data   = 16'h0202;
    in_ctrl   = 12'h022;
    out_ready = 1'b0;
    #1;
    check("flop in_ready comb drop", 1, 32'(in_ready_v[1]), 32'd0);
    check("skid in_ready still up",  0, 32'(in_ready_v[0]), 32'd1);
    @(posedge clk);
    #1;
    check("skid full in_ready", 0, 32'(in_ready_v[0]), 32'd0);
    step(1'b1, 16'h0303, 12'h033, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0303, 12'h033, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0303, 12'h033, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL with a bundle arriving
    step(1'b1, 16'h0A0A, 12'h0AA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0B0B, 12'h0BB, 1'b0, 1'b0, 1'b0);
    check("pre-flush in_ready", 0, 32'(in_ready_v[0]), 32'd0);
    step(1'b1, 16'h0C0C, 12'h0CC, 1'b0, 1'b1, 1'b0);
    check("flush out_valid", 0, 32'(out_valid_v[0]), 32'd0);
    check("flush out_ctrl",  0, 32'(out_ctrl_v[0]),  32'd0);
    check("flush in_ready",  0, 32'(in_ready_v[0]),  32'd1);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Stall counter saturation and clear
    step(1'b1, 16'h0D0D, 12'h0DD, 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("stall saturated", 0, 32'(stall_cnt_v[0]), 32'(CNT_MAX));
    check("stall saturated", 1, 32'(stall_cnt_v[1]), 32'(CNT_MAX));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("stall cleared", 0, 32'(stall_cnt_v[0]), 32'd0);
    check("stall cleared", 1, 32'(stall_cnt_v[1]), 32'd0);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), DW'($urandom), CW'($urandom),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset in the middle of a stream
    repeat (3) step(1'b1, DW'($urandom), CW'($urandom | 1), 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 1, 32'(out_valid_v[1]), 32'd0);
    check("async rst out_ctrl",  1, 32'(out_ctrl_v[1]),  32'd0);
    check("async rst out_valid", 0, 32'(out_valid_v[0]), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised pipeline-stage register; the successor to the fixed-width ID/EX-style stage registers.
- Carries one bundle between two pipeline stages: a data field and a control field.
- Adds a valid/ready handshake, a synchronous flush that injects a bubble, and an optional 2-entry skid buffer.
- The skid buffer gives full throughput with a registered in_ready. A saturating back-pressure counter supports performance debug.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB in the next core revision.

Parameters:
- DATA_W, 64, width of the payload (pc, immediate, operands, rd, funct fields packed by the caller).
- CTRL_W, 12, width of the control field (ALUOp, mem_read/write, regs_write, ...); forced to zero whenever the stage holds a bubble.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; drops all held and incoming bundles.
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  stage can accept a bundle this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bits.
- out_valid  output  1  bundle presented downstream.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  registered payload.
- out_ctrl  output  CTRL_W  registered control; all-zero when out_valid=0.
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - Skid entry is empty and zeroed.
  - in_ready=1 once rst_n deasserts (SKID_EN=1); in_ready=1 (SKID_EN=0, since out_valid=0).
- Transfer rules:
  - Input handshake: in_valid & in_ready.
  - Output handshake: out_valid & out_ready.
  - No data leaves or enters outside these handshakes.
- Latency: 1 cycle from input handshake to out_valid when the main register is empty or drains that cycle.
- Data hold: out_data and out_ctrl hold stable while out_valid=1 and out_ready=0.
- SKID_EN=1:
  - in_ready = !skid_valid. It is a flop output with no combinational path from out_ready.
  - States by (main_valid, skid_valid):
    - EMPTY (0,0).
    - ONE (1,0).
    - FULL (1,1).
  - EMPTY: input handshake -> ONE, main loads input.
  - ONE:
    - in & out handshake -> ONE, main loads input.
    - in only -> FULL, skid loads input.
    - out only -> EMPTY.
  - FULL:
    - in_ready=0.
    - out handshake -> ONE, main loads skid.
    - otherwise hold.
  - Order is preserved; the skid entry is always older than the next input.
  - Sustained throughput is 1 bundle/cycle when out_ready=1 continuously.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - Main loads on input handshake; clears valid on output handshake without an input handshake.
- Bubbles: whenever main_valid becomes 0, out_ctrl is written to 0 (bubble carries no side effects); out_data keeps its last value.
- Flush:
  - Highest priority.
  - Next cycle: out_valid=0, skid empty, out_ctrl=0.
  - An input handshake in the flush cycle is discarded.
  - in_ready=1 the following cycle.
  - The stall counter is unaffected.
- Stall counter:
  - Increments each cycle out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - stall_clr has priority over increment; count is 0 next cycle.
- Simultaneous events:
  - flush with stall_clr: both apply.
  - flush with out handshake: the downstream handshake completes this cycle and the stage empties.
- Reset mid-operation clears all state immediately, regardless of clk.

Test Plan:
- Reset, then in_valid=1 with in_data=0x1234, in_ctrl=0x0A5, out_ready=1 -> out_valid=1, out_data=0x1234, out_ctrl=0x0A5 one cycle later; in_ready stays 1.
- Streaming 8 bundles (data 1..8), out_ready=1 throughout -> out_data 1..8 on consecutive cycles, no gaps, in_ready never drops.
- Back-pressure: out_ready=0 after bundle 1, continue driving bundles 2, 3 -> bundle 2 sits in skid, in_ready=0 next cycle, bundle 3 held upstream. out_ready=1 -> outputs 1,2,3 in order, no loss or duplicate.
- flush asserted while FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the flushed and incoming bundles never appear.
- stall_cnt, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). Then stall_clr=1 -> stall_cnt=0 next cycle.
- SKID_EN=0 variant: out_ready=0 with a valid bundle -> in_ready=0 in the same cycle. Assert rst_n=0 mid-stream -> out_valid=0 and out_ctrl=0 immediately, asynchronously.
